// File: rtl/gfx_frame_reg_sync.sv
// Double-buffered graphics register file: CPU writes land in staging registers
// and are committed to the active set only at end of frame, so objects never tear.
module gfx_frame_reg_sync #(
  parameter logic [3:0]  CS_ID     = 4'd2,
  parameter logic [18:0] LAST_ADDR = 19'h4AFFF,
  parameter int          NUM_REGS  = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          chipselect,
  input  logic [15:0]         databus,
  input  logic [3:0]          data_address,
  input  logic                VGA_ready,
  input  logic [18:0]         pixel_address,
  input  logic                commit_en,
  output logic [15:0]         paddle_1_x,
  output logic [15:0]         paddle_1_y,
  output logic [15:0]         paddle_2_x,
  output logic [15:0]         paddle_2_y,
  output logic [15:0]         ball_x,
  output logic [15:0]         ball_y,
  output logic [15:0]         ball_z,
  output logic [15:0]         player_1_score,
  output logic [15:0]         player_2_score,
  output logic [15:0]         game_state,
  output logic [NUM_REGS-1:0] pending,
  output logic                commit_done,
  output logic                overwrite_err,
  output logic                addr_err,
  output logic [15:0]         frame_count
);

  // state | meaning
  // IDLE  | nothing staged
  // ARMED | staged writes waiting for end of frame
  // DONE  | commit happened on the previous edge (commit_done high)
  typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

  state_t            state;
  logic [15:0]       staging [NUM_REGS];
  logic [15:0]       active  [NUM_REGS];

  logic                frame_end;
  logic                write;
  logic                wr_valid;
  logic                commit;
  logic [NUM_REGS-1:0] wr_mask;
  logic [NUM_REGS-1:0] pending_next;

  function automatic logic [15:0] reset_val(input int idx);
    case (idx)
      0:       reset_val = 16'd100;
      1:       reset_val = 16'd200;
      2:       reset_val = 16'd350;
      3:       reset_val = 16'd250;
      4:       reset_val = 16'd305;
      5:       reset_val = 16'd240;
      default: reset_val = 16'd0;
    endcase
  endfunction

  always_comb begin
    frame_end = VGA_ready && (pixel_address == LAST_ADDR);
    write     = (chipselect == CS_ID);
    wr_valid  = write && (data_address < 4'(NUM_REGS));
    // Commit depends only on pending, so a back-to-back frame_end in DONE acts like ARMED
    commit    = frame_end && commit_en && (|pending);
    wr_mask   = '0;
    for (int i = 0; i < NUM_REGS; i++)
      wr_mask[i] = wr_valid && (data_address == 4'(i));
    pending_next = (commit ? '0 : pending) | wr_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pending       <= '0;
      overwrite_err <= 1'b0;
      addr_err      <= 1'b0;
      frame_count   <= 16'd0;
      for (int i = 0; i < NUM_REGS; i++) begin
        staging[i] <= reset_val(i);
        active[i]  <= reset_val(i);
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit && pending[i])
          active[i] <= staging[i];
        if (wr_mask[i])
          staging[i] <= databus;
      end
      pending <= pending_next;
      // A re-write racing a commit of the same index is a legitimate next-frame update
      if ((|(wr_mask & pending)) && !commit)
        overwrite_err <= 1'b1;
      if (write && !wr_valid)
        addr_err <= 1'b1;
      if (frame_end)
        frame_count <= frame_count + 16'd1;
      case (state)
        IDLE:    state <= (|pending_next) ? ARMED : IDLE;
        default: begin
          if (commit)               state <= DONE;
          else if (|pending_next)   state <= ARMED;
          else                      state <= IDLE;
        end
      endcase
    end
  end

  assign commit_done    = (state == DONE);
  assign paddle_1_x     = active[0];
  assign paddle_1_y     = active[1];
  assign paddle_2_x     = active[2];
  assign paddle_2_y     = active[3];
  assign ball_x         = active[4];
  assign ball_y         = active[5];
  assign ball_z         = active[6];
  assign player_1_score = active[7];
  assign player_2_score = active[8];
  assign game_state     = active[9];

endmodule

// File: tb/tb_gfx_frame_reg_sync.sv
// Bench for gfx_frame_reg_sync: directed vector table, hand sequences for the
// commit corner cases, then random traffic against a frame-level reference model.
module tb_gfx_frame_reg_sync;

  localparam logic [18:0] LAST = 19'h4AFFF;
  localparam logic [3:0]  CS   = 4'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  chipselect;
  logic [15:0] databus;
  logic [3:0]  data_address;
  logic        VGA_ready;
  logic [18:0] pixel_address;
  logic        commit_en;
  logic [15:0] paddle_1_x, paddle_1_y, paddle_2_x, paddle_2_y;
  logic [15:0] ball_x, ball_y, ball_z, player_1_score, player_2_score, game_state;
  logic [9:0]  pending;
  logic        commit_done, overwrite_err, addr_err;
  logic [15:0] frame_count;

  gfx_frame_reg_sync dut (
    .clk(clk), .rst(rst), .chipselect(chipselect), .databus(databus),
    .data_address(data_address), .VGA_ready(VGA_ready), .pixel_address(pixel_address),
    .commit_en(commit_en), .paddle_1_x(paddle_1_x), .paddle_1_y(paddle_1_y),
    .paddle_2_x(paddle_2_x), .paddle_2_y(paddle_2_y), .ball_x(ball_x), .ball_y(ball_y),
    .ball_z(ball_z), .player_1_score(player_1_score), .player_2_score(player_2_score),
    .game_state(game_state), .pending(pending), .commit_done(commit_done),
    .overwrite_err(overwrite_err), .addr_err(addr_err), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the staged set, the displayed set and the bookkeeping
  logic [15:0] m_stg [10];
  logic [15:0] m_act [10];
  logic [9:0]  m_pend;
  logic        m_done, m_ow, m_ae;
  logic [15:0] m_fc;
  logic [15:0] init_vals [10] = '{16'd100, 16'd200, 16'd350, 16'd250, 16'd305,
                                  16'd240, 16'd0, 16'd0, 16'd0, 16'd0};

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic logic [15:0] dut_reg(input int i);
    case (i)
      0: return paddle_1_x;      1: return paddle_1_y;
      2: return paddle_2_x;      3: return paddle_2_y;
      4: return ball_x;          5: return ball_y;
      6: return ball_z;          7: return player_1_score;
      8: return player_2_score;  default: return game_state;
    endcase
  endfunction

  task automatic model_clock();
    logic fe, commit;
    logic [15:0] old_stg [10];
    logic [9:0]  old_pend;
    int a;
    if (rst) begin
      m_stg = init_vals; m_act = init_vals;
      m_pend = '0; m_done = 0; m_ow = 0; m_ae = 0; m_fc = 0;
      return;
    end
    fe       = VGA_ready && (pixel_address == LAST);
    commit   = fe && commit_en && (m_pend != 0);
    old_stg  = m_stg;
    old_pend = m_pend;
    if (commit) begin
      for (int i = 0; i < 10; i++) if (old_pend[i]) m_act[i] = old_stg[i];
      m_pend = '0;
    end
    if (chipselect == CS) begin
      a = int'(data_address);
      if (a < 10) begin
        if (old_pend[a] && !commit) m_ow = 1;
        m_stg[a]  = databus;
        m_pend[a] = 1'b1;
      end else begin
        m_ae = 1;
      end
    end
    m_done = commit;
    if (fe) m_fc = m_fc + 16'd1;
  endtask

  task automatic check_all();
    for (int i = 0; i < 10; i++) chk($sformatf("reg%0d", i), dut_reg(i), m_act[i]);
    chk("pending", pending, m_pend);
    chk("commit_done", commit_done, m_done);
    chk("overwrite_err", overwrite_err, m_ow);
    chk("addr_err", addr_err, m_ae);
    chk("frame_count", frame_count, m_fc);
  endtask

  task automatic step(input logic r, input logic [3:0] cs, input logic [3:0] a,
                      input logic [15:0] d, input logic vga, input logic [18:0] pix,
                      input logic cen);
    rst = r; chipselect = cs; data_address = a; databus = d;
    VGA_ready = vga; pixel_address = pix; commit_en = cen;
    @(posedge clk);
    model_clock();
    #1;
    check_all();
  endtask

  // One cycle: optional write, optional frame_end
  task automatic cyc(input logic r, input logic wr, input logic [3:0] a,
                     input logic [15:0] d, input logic fe, input logic cen);
    step(r, wr ? CS : 4'd0, a, d, 1'b1, fe ? LAST : 19'h00123, cen);
  endtask

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [15:0] data;
    logic        fe;
    logic        cen;
    logic [15:0] exp_p1x;
    logic [9:0]  exp_pend;
    logic        exp_done;
  } vec_t;

  vec_t vecs [8];
  logic [15:0] fc_base;
  logic [9:0]  pend_before;

  initial begin
    vecs[0] = '{0, 4'd0, 16'd0,   0, 1, 16'd100, 10'h000, 0};
    vecs[1] = '{1, 4'd0, 16'd150, 0, 1, 16'd100, 10'h001, 0};
    vecs[2] = '{0, 4'd0, 16'd0,   0, 1, 16'd100, 10'h001, 0};
    vecs[3] = '{0, 4'd0, 16'd0,   1, 1, 16'd150, 10'h000, 1};
    vecs[4] = '{0, 4'd0, 16'd0,   0, 1, 16'd150, 10'h000, 0};
    vecs[5] = '{1, 4'd0, 16'd7,   1, 0, 16'd150, 10'h001, 0};
    vecs[6] = '{0, 4'd0, 16'd0,   1, 1, 16'd7,   10'h000, 1};
    vecs[7] = '{0, 4'd0, 16'd0,   1, 1, 16'd7,   10'h000, 0};

    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("rst_p1x", paddle_1_x, 16'd100);
    chk("rst_p2y", paddle_2_y, 16'd250);
    chk("rst_ballx", ball_x, 16'd305);
    chk("rst_pending", pending, 10'h000);
    chk("rst_fc", frame_count, 16'd0);

    for (int v = 0; v < 8; v++) begin
      cyc(0, vecs[v].wr, vecs[v].addr, vecs[v].data, vecs[v].fe, vecs[v].cen);
      chk($sformatf("vec%0d_p1x", v), paddle_1_x, vecs[v].exp_p1x);
      chk($sformatf("vec%0d_pend", v), pending, vecs[v].exp_pend);
      chk($sformatf("vec%0d_done", v), commit_done, vecs[v].exp_done);
    end

    // Same-index write racing a commit
    cyc(1, 0, 0, 0, 0, 1);
    cyc(0, 1, 4'd7, 16'd1, 0, 1);
    cyc(0, 1, 4'd7, 16'd3, 1, 1);
    chk("race_score", player_1_score, 16'd1);
    chk("race_pend7", pending[7], 1'b1);
    chk("race_ow", overwrite_err, 1'b0);
    cyc(0, 0, 0, 0, 1, 1);
    chk("race_score_next", player_1_score, 16'd3);

    // Paused commits
    fc_base = m_fc;
    cyc(0, 1, 4'd9, 16'd2, 0, 1);
    cyc(0, 0, 0, 0, 1, 0);
    chk("pause_done1", commit_done, 1'b0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("pause_done2", commit_done, 1'b0);
    chk("pause_gs", game_state, 16'd0);
    chk("pause_fc", frame_count, fc_base + 16'd2);
    cyc(0, 0, 0, 0, 1, 1);
    chk("resume_gs", game_state, 16'd2);

    // Overwrite before commit
    cyc(0, 1, 4'd6, 16'd10, 0, 1);
    cyc(0, 1, 4'd6, 16'd20, 0, 1);
    chk("ow_flag", overwrite_err, 1'b1);
    cyc(0, 0, 0, 0, 1, 1);
    chk("ow_ballz", ball_z, 16'd20);

    // Bad address, then reset with a pending write
    cyc(0, 1, 4'd3, 16'd9, 0, 1);
    pend_before = m_pend;
    cyc(0, 1, 4'd12, 16'hBEEF, 0, 1);
    chk("ae_flag", addr_err, 1'b1);
    chk("ae_pend", pending, pend_before);
    cyc(0, 1, 4'd1, 16'd55, 0, 1);
    cyc(1, 0, 0, 0, 0, 1);
    chk("rst_mid_p1y", paddle_1_y, 16'd200);
    chk("rst_mid_pend", pending, 10'h000);
    chk("rst_mid_ae", addr_err, 1'b0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      logic r, vga, cen;
      logic [3:0] cs, a;
      logic [18:0] pix;
      r   = ($urandom_range(0, 99) == 0);
      cs  = ($urandom_range(0, 2) != 0) ? CS : 4'($urandom_range(0, 15));
      a   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      vga = ($urandom_range(0, 3) != 0);
      pix = ($urandom_range(0, 3) == 0) ? LAST : 19'($urandom_range(0, 32'h4AFFE));
      cen = ($urandom_range(0, 4) != 0);
      step(r, cs, a, 16'($urandom), vga, pix, cen);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
